// File: rtl/ysyx_220053_lsu_pkg.sv
// Shared types and helpers for the ysyx_220053 load/store unit.
// No logic of its own; used by the FSM top and the alignment datapath.
// State encoding, funct3 size codes, byte-mask and alignment helpers.
package ysyx_220053_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;
    localparam logic [2:0] SZ_ILLEGAL = 3'b111;

    // Byte enables of an access of the given width, before lane shifting.
    function automatic logic [7:0] base_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Natural alignment check; the width is carried in size[1:0] for all codes.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// Byte-lane steering: store data/mask shift and load extract/extend.
// Purely combinational, zero latency.
// No flow control; the caller qualifies outputs with its own state.
module ysyx_220053_lsu_align
    import ysyx_220053_lsu_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [2:0]  size,
    input  logic [63:0] st_data_in,
    input  logic [63:0] ld_data_in,
    output logic [63:0] st_wdata,
    output logic [7:0]  st_wmask,
    output logic [63:0] ld_data
);

    logic [5:0]  bit_off;
    logic [63:0] ld_shifted;

    assign bit_off    = {off, 3'b000};
    assign st_wdata   = st_data_in << bit_off;
    assign st_wmask   = base_mask(size[1:0]) << off;
    assign ld_shifted = ld_data_in >> bit_off;

    // Pick the addressed bytes from the right-aligned word and extend them.
    always_comb begin
        ld_data = ld_shifted;
        case (size)
            SZ_B:    ld_data = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
            SZ_H:    ld_data = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W:    ld_data = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            SZ_BU:   ld_data = {56'd0, ld_shifted[7:0]};
            SZ_HU:   ld_data = {48'd0, ld_shifted[15:0]};
            SZ_WU:   ld_data = {32'd0, ld_shifted[31:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: one data-memory transaction per accepted instruction.
// Latency: 3 cycles minimum (accept, bus request, response); 1 cycle on error.
// Backpressure: req_ready only in IDLE; REQ holds the bus request until mem_req_ready.
module ysyx_220053_lsu
    import ysyx_220053_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [2:0]  size_q, size_d;
    logic [63:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic [63:0] st_wdata;
    logic [7:0]  st_wmask;
    logic [63:0] ld_data;
    logic        req_bad;

    ysyx_220053_lsu_align u_align (
        .off        (addr_q[2:0]),
        .size       (size_q),
        .st_data_in (wdata_q),
        .ld_data_in (mem_rdata),
        .st_wdata   (st_wdata),
        .st_wmask   (st_wmask),
        .ld_data    (ld_data)
    );

    // Stores only look at size[1:0], so the illegal code exists only for loads.
    assign req_bad = (!req_wen && (req_size == SZ_ILLEGAL))
                   || misaligned(req_size[1:0], req_addr[2:0]);

    // Next-state and capture logic for the four-state transaction FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    rdata_d = 64'd0;
                    state_d = req_bad ? RESP : REQ;
                end
            end
            REQ: begin
                // A same-cycle mem_resp_valid is not taken here; data comes in WAIT.
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? 64'd0 : ld_data;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 64'd0;
            wen_q   <= 1'b0;
            size_q  <= 3'd0;
            wdata_q <= 64'd0;
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus outputs come only from registers and state, never from req_*.
    assign req_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = {addr_q[63:3], 3'b000};
    assign mem_wen       = wen_q;
    assign mem_wdata     = st_wdata;
    assign mem_wmask     = wen_q ? st_wmask : 8'h00;
    assign resp_valid    = (state_q == RESP);
    assign resp_err      = resp_valid & err_q;
    assign resp_rdata    = rdata_q;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// Directed self-checking bench for the load/store unit.
// Inputs driven and outputs sampled on the falling clock edge.
// The bench plays the memory: it raises ready after a set stall, then returns one response.
module tb_ysyx_220053_lsu;
    import ysyx_220053_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [2:0]  req_size = 3'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_mreq_seen;
    logic        obs_stable;
    int          obs_lat;
    logic [63:0] obs_rdata;
    logic        obs_err;
    logic        obs_single;
    logic [63:0] obs_mem_addr;
    logic        obs_mem_wen;
    logic [63:0] obs_mem_wdata;
    logic [7:0]  obs_mem_wmask;

    always #5 clk = ~clk;

    ysyx_220053_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    // Drive one request and act as memory; results land in the obs_* variables.
    task automatic run_txn(input logic [63:0] a, input logic w, input logic [2:0] sz,
                           input logic [63:0] wd, input logic [63:0] rd, input int stall);
        int cyc;
        int nreq;
        bit done;
        obs_mreq_seen = 1'b0; obs_stable = 1'b1; obs_lat = -1;
        obs_rdata = 64'hx; obs_err = 1'bx; obs_single = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 64'hFFFF_FFFF_FFFF_FFFF; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wen = ~w; req_size = 3'b111;
        cyc = 1; nreq = 0; done = 0;
        while (!done && cyc < 40) begin
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
            if (resp_valid) begin
                obs_lat = cyc; obs_rdata = resp_rdata; obs_err = resp_err; done = 1;
            end else if (mem_req_valid) begin
                if (!obs_mreq_seen) begin
                    obs_mreq_seen = 1'b1;
                    obs_mem_addr = mem_addr; obs_mem_wen = mem_wen;
                    obs_mem_wdata = mem_wdata; obs_mem_wmask = mem_wmask;
                end else if (mem_addr !== obs_mem_addr || mem_wen !== obs_mem_wen ||
                             mem_wdata !== obs_mem_wdata || mem_wmask !== obs_mem_wmask) begin
                    obs_stable = 1'b0;
                end
                if (nreq >= stall) mem_req_ready = 1'b1;
                nreq++;
            end else if (obs_mreq_seen) begin
                mem_resp_valid = 1'b1; mem_rdata = rd;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        obs_single = !resp_valid && req_ready;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if ({req_ready, busy, mem_req_valid, resp_valid, resp_err, mem_wen} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=100000", {req_ready, busy, mem_req_valid, resp_valid, resp_err, mem_wen}); end
        n_checks++; if ({mem_addr, mem_wdata, mem_wmask, resp_rdata} !== 200'd0) begin
            n_fail++; $display("FAIL reset_data addr=%h wdata=%h wmask=%h rdata=%h exp=all 0", mem_addr, mem_wdata, mem_wmask, resp_rdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lb;
        run_txn(64'h8000_0003, 1'b0, SZ_B, 64'd0, 64'h0000_0000_8000_0000, 0);
        n_checks++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_fail++; $display("FAIL lb_rdata got=%h exp=ffffffffffffff80", obs_rdata); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL lb_err got=%b exp=0", obs_err); end
        n_checks++; if (obs_lat !== 3) begin n_fail++; $display("FAIL lb_latency got=%0d exp=3", obs_lat); end
        n_checks++; if (obs_mem_addr !== 64'h8000_0000 || obs_mem_wmask !== 8'h00 || obs_mem_wen !== 1'b0) begin
            n_fail++; $display("FAIL lb_bus addr=%h wmask=%h wen=%b exp=80000000/00/0", obs_mem_addr, obs_mem_wmask, obs_mem_wen); end
        n_checks++; if (obs_single !== 1'b1) begin n_fail++; $display("FAIL lb_single_pulse got=%b exp=1", obs_single); end
    endtask

    task automatic test_store;
        run_txn(64'h8000_0004, 1'b1, SZ_W, 64'h0000_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        n_checks++; if (obs_mem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL sw_addr got=%h exp=80000000", obs_mem_addr); end
        n_checks++; if (obs_mem_wmask !== 8'hF0 || obs_mem_wen !== 1'b1) begin
            n_fail++; $display("FAIL sw_mask got=%h/%b exp=f0/1", obs_mem_wmask, obs_mem_wen); end
        n_checks++; if (obs_mem_wdata !== 64'h1234_5678_0000_0000) begin
            n_fail++; $display("FAIL sw_wdata got=%h exp=1234567800000000", obs_mem_wdata); end
        n_checks++; if (obs_rdata !== 64'd0 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL sw_resp got=%h/%b exp=0/0", obs_rdata, obs_err); end
        run_txn(64'h8000_0007, 1'b1, SZ_B, 64'h0000_0000_0000_00AB, 64'd0, 0);
        n_checks++; if (obs_mem_wmask !== 8'h80 || obs_mem_wdata !== 64'hAB00_0000_0000_0000) begin
            n_fail++; $display("FAIL sb_lane got=%h/%h exp=80/ab00000000000000", obs_mem_wmask, obs_mem_wdata); end
    endtask

    task automatic test_errors;
        run_txn(64'h8000_0001, 1'b0, SZ_H, 64'd0, 64'd0, 0);
        n_checks++; if (obs_err !== 1'b1 || obs_lat !== 1) begin
            n_fail++; $display("FAIL lh_misalign got err=%b lat=%0d exp err=1 lat=1", obs_err, obs_lat); end
        n_checks++; if (obs_mreq_seen !== 1'b0 || obs_rdata !== 64'd0) begin
            n_fail++; $display("FAIL lh_no_bus got mreq=%b rdata=%h exp 0/0", obs_mreq_seen, obs_rdata); end
        run_txn(64'h8000_0000, 1'b0, SZ_ILLEGAL, 64'd0, 64'd0, 0);
        n_checks++; if (obs_err !== 1'b1 || obs_lat !== 1 || obs_mreq_seen !== 1'b0) begin
            n_fail++; $display("FAIL illegal_size got err=%b lat=%0d mreq=%b exp 1/1/0", obs_err, obs_lat, obs_mreq_seen); end
        run_txn(64'h8000_0004, 1'b1, SZ_D, 64'h1, 64'd0, 0);
        n_checks++; if (obs_err !== 1'b1 || obs_mreq_seen !== 1'b0) begin
            n_fail++; $display("FAIL sd_misalign got err=%b mreq=%b exp 1/0", obs_err, obs_mreq_seen); end
        run_txn(64'h8000_0006, 1'b0, SZ_W, 64'd0, 64'd0, 0);
        n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL lw_misalign got err=%b exp=1", obs_err); end
    endtask

    task automatic test_stall;
        run_txn(64'h8000_0008, 1'b0, SZ_D, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 3);
        n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL ld_stall_stable got=%b exp=1", obs_stable); end
        n_checks++; if (obs_mem_addr !== 64'h8000_0008 || obs_mem_wmask !== 8'h00) begin
            n_fail++; $display("FAIL ld_bus got=%h/%h exp=80000008/00", obs_mem_addr, obs_mem_wmask); end
        n_checks++; if (obs_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
            n_fail++; $display("FAIL ld_rdata got=%h exp=deadbeefcafef00d", obs_rdata); end
        n_checks++; if (obs_lat !== 6) begin n_fail++; $display("FAIL ld_stall_latency got=%0d exp=6", obs_lat); end
    endtask

    task automatic test_extend;
        run_txn(64'h8000_0004, 1'b0, SZ_WU, 64'd0, 64'hFFFF_FFFF_0000_0000, 0);
        n_checks++; if (obs_rdata !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++; $display("FAIL lwu_rdata got=%h exp=00000000ffffffff", obs_rdata); end
        run_txn(64'h8000_0006, 1'b0, SZ_H, 64'd0, 64'h8001_0000_0000_0000, 0);
        n_checks++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin
            n_fail++; $display("FAIL lh_rdata got=%h exp=ffffffffffff8001", obs_rdata); end
        run_txn(64'h8000_0002, 1'b0, SZ_BU, 64'd0, 64'h0000_0000_00FF_0000, 0);
        n_checks++; if (obs_rdata !== 64'h0000_0000_0000_00FF) begin
            n_fail++; $display("FAIL lbu_rdata got=%h exp=00000000000000ff", obs_rdata); end
    endtask

    // Ready and response together in REQ: only the ready counts.
    task automatic test_ready_resp_same;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h8000_0010; req_wen = 1'b0; req_size = SZ_W;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h0000_0000_1111_1111;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_wait got rv=%b busy=%b mreq=%b exp 0/1/0", resp_valid, busy, mem_req_valid); end
        mem_resp_valid = 1'b1; mem_rdata = 64'h0000_0000_8765_4321;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFF_FFFF_8765_4321) begin
            n_fail++; $display("FAIL same_cycle_data got rv=%b rdata=%h exp 1/ffffffff87654321", resp_valid, resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h8000_0018; req_wen = 1'b1; req_size = SZ_D; req_wdata = 64'h55;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_checks++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait got busy=%b mreq=%b exp 1/0", busy, mem_req_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || mem_addr !== 64'd0 || mem_wmask !== 8'h00 || mem_wen !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got rdy=%b busy=%b addr=%h wmask=%h wen=%b", req_ready, busy, mem_addr, mem_wmask, mem_wen); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 64'h1234;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_resp got seen=%0d rdy=%b busy=%b exp 0/1/0", seen, req_ready, busy); end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_store;
        test_errors;
        test_stall;
        test_extend;
        test_ready_resp_same;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_lsu.md
# ysyx_220053_lsu

Load/store unit sitting directly downstream of the ALU in the ysyx_220053 core. It takes the ALU sum (base + offset) as the effective address and runs one data-memory transaction per instruction over a valid/ready bus. On stores it generates the byte lane mask and shifted write data. On loads it extracts and sign- or zero-extends the selected bytes. It returns a one-cycle completion pulse to the core, which stalls while `busy` is high.

## Interface
Parameters:
- None. Address and data widths are fixed at 64.

Ports (name, direction, width, meaning):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core offers a memory instruction.
- `req_ready`  out  1  unit accepts the offered instruction; high only in IDLE.
- `req_addr`  in  64  effective address (ALU result).
- `req_wen`  in  1  1 = store, 0 = load.
- `req_size`  in  3  funct3 encoding:
  - 000 b, 001 h, 010 w, 011 d
  - 100 bu, 101 hu, 110 wu
  - 111 is illegal
  - for stores, only bit[1:0] is used.
- `req_wdata`  in  64  store data (rs2), right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or illegal size; qualified by `resp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `mem_req_valid`  out  1  bus request.
- `mem_req_ready`  in  1  bus accepts the request.
- `mem_addr`  out  64  `{addr[63:3], 3'b000}`.
- `mem_wen`  out  1  write request.
- `mem_wdata`  out  64  `wdata << (8*addr[2:0])`.
- `mem_wmask`  out  8  byte enables; 0 on reads.
- `mem_resp_valid`  in  1  read data valid, or write acknowledged.
- `mem_rdata`  in  64  aligned 64-bit read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, capture addr/wen/size/wdata into registers.
  - If size is illegal, or the address is misaligned, go to RESP with the error flag set. No bus access is made.
  - Otherwise go to REQ.
- Alignment rules:
  - h requires addr[0]=0.
  - w requires addr[1:0]=0.
  - d requires addr[2:0]=0.
  - b is always aligned.
- REQ: `mem_req_valid`=1 with stable addr/wen/wdata/wmask. On `mem_req_ready`=1, go to WAIT. Otherwise hold all bus outputs unchanged.
- WAIT: on `mem_resp_valid`=1, register the extended load data (or 0 for stores), then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE.
- Write mask: base mask by size (b 0x01, h 0x03, w 0x0F, d 0xFF), shifted left by addr[2:0].
- Load path:
  - shifted = `mem_rdata >> (8*addr[2:0])`.
  - Take the low 8/16/32/64 bits.
  - Sign-extend for b/h/w; zero-extend for bu/hu/wu. d passes through unchanged.
- `mem_resp_valid` is ignored outside WAIT.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - State goes to IDLE.
  - All outputs are 0 except `req_ready`=1.
  - All captured registers are cleared.
- Reset mid-transaction abandons the transaction. No `resp_valid` is issued for it.
- Latency:
  - Accept edge at cycle 0.
  - `mem_req_valid` is high from cycle 1.
  - With `mem_req_ready` high in cycle 1 and `mem_resp_valid` high in cycle 2, `resp_valid` is high in cycle 3.
  - Minimum total is 3 cycles.
- Error path: accept in cycle 0, `resp_valid` and `resp_err` high in cycle 1.
- `mem_req_ready` and `mem_resp_valid` both high in REQ: only the ready is taken. The response is expected in a later cycle.
- `mem_*` outputs are registered or decoded from state. There is no combinational path from `req_*` to `mem_*`.
- Back-to-back: the earliest next accept is the cycle after RESP.

## Structure
- Package `ysyx_220053_lsu_pkg`:
  - state enum {IDLE, REQ, WAIT, RESP}.
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_D, SZ_BU, SZ_HU, SZ_WU.
  - function `base_mask(size)`.
- Sub-module `ysyx_220053_lsu_align`: combinational store shift and mask generation, plus load shift and extension. Instantiated once.
- Top level holds the FSM and the capture registers.

## Test plan
1. lb, addr 0x80000003, `mem_rdata` 0x00000000_80000000 → `resp_rdata` 0xFFFFFFFF_FFFFFF80, `resp_err`=0.
2. sw, addr 0x80000004, wdata 0x1234_5678 → `mem_addr` 0x80000000, `mem_wmask` 0xF0, `mem_wdata` 0x12345678_00000000, `resp_rdata`=0.
3. lh, addr 0x80000001 → `resp_valid` and `resp_err`=1 one cycle after accept, `mem_req_valid` never asserted.
4. ld, addr 0x80000008, `mem_req_ready` low 3 cycles → bus outputs held stable; `mem_rdata` 0xDEADBEEF_CAFEF00D returned unchanged.
5. lwu, addr 0x80000004, `mem_rdata` 0xFFFFFFFF_00000000 → `resp_rdata` 0x00000000_FFFFFFFF.
6. `rst_n` low during WAIT, then `mem_resp_valid` pulse → no `resp_valid`; state IDLE; `req_ready`=1.
